// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5..8 data bits, optional parity,
// programmable stop length, one-cycle done strobe with error flags.
module uart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int SB_TICK     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    input  logic [3:0] data_bits,
    input  logic [5:0] stop_bits,
    input  logic [1:0] parity_bits,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t state, state_n;

    logic [NS-1:0] sync;
    logic          rxs;
    logic [5:0]    s_reg, s_n;
    logic [2:0]    n_reg, n_n;
    logic [7:0]    b_reg, b_n;
    logic          p_reg, p_n;
    logic          stp_reg, stp_n;
    logic          hold_reg, hold_n;
    logic          fin;

    logic [3:0] nbits;
    logic [2:0] last_n;
    logic [5:0] stop_len;
    logic [5:0] last_tick;
    logic [7:0] data_w;
    logic       pbit_x;
    logic       perr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '1;
        else       sync <= {sync[NS-2:0], rx};
    end

    assign rxs = sync[NS-1];

    assign nbits = (data_bits >= 4'd5 && data_bits <= 4'd8) ?
                   data_bits : 4'd8;
    assign last_n    = nbits[2:0] - 3'd1;
    assign stop_len  = (stop_bits == 6'd0) ? 6'(SB_TICK) : stop_bits;
    assign last_tick = stop_len - 6'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            s_reg    <= '0;
            n_reg    <= '0;
            b_reg    <= '0;
            p_reg    <= 1'b0;
            stp_reg  <= 1'b1;
            hold_reg <= 1'b0;
        end else begin
            state    <= state_n;
            s_reg    <= s_n;
            n_reg    <= n_n;
            b_reg    <= b_n;
            p_reg    <= p_n;
            stp_reg  <= stp_n;
            hold_reg <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s_reg;
        n_n     = n_reg;
        b_n     = b_reg;
        p_n     = p_reg;
        stp_n   = stp_reg;
        hold_n  = hold_reg;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                // after a break, wait for the line to return high
                if (hold_reg && rxs) hold_n = 1'b0;
                if (!hold_reg && !rxs) begin
                    s_n     = '0;
                    state_n = START;
                end
            end
            START: if (s_tick) begin
                if (s_reg == 6'd7) begin
                    if (!rxs) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    s_n = s_reg + 6'd1;
                end
            end
            DATA: if (s_tick) begin
                if (s_reg == 6'd15) begin
                    b_n = {rxs, b_reg[7:1]};
                    s_n = '0;
                    if (n_reg == last_n)
                        state_n = (parity_bits != 2'd0) ? PARITY : STOP;
                    else
                        n_n = n_reg + 3'd1;
                end else begin
                    s_n = s_reg + 6'd1;
                end
            end
            PARITY: if (s_tick) begin
                if (s_reg == 6'd15) begin
                    p_n     = rxs;
                    s_n     = '0;
                    state_n = STOP;
                end else begin
                    s_n = s_reg + 6'd1;
                end
            end
            STOP: if (s_tick) begin
                if (s_reg == 6'd15 ||
                    (s_reg == last_tick && stop_len < 6'd16))
                    stp_n = rxs;
                if (s_reg == last_tick) begin
                    fin     = 1'b1;
                    hold_n  = ~stp_n;
                    state_n = IDLE;
                end else begin
                    s_n = s_reg + 6'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        data_w  = b_reg >> (4'd8 - nbits);
        pbit_x  = (^data_w) ^ p_reg;
        perr    = 1'b0;
        if (parity_bits == 2'd1)      perr = ~pbit_x;
        else if (parity_bits != 2'd0) perr = pbit_x;
        rx_busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout         <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= fin;
            if (fin) begin
                dout       <= data_w;
                parity_err <= perr;
                frame_err  <= ~stp_n;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bench-generated serial frames,
// done pulses captured into a queue and compared to fixed values.
module tb_uart_rx;
    logic       clk = 0;
    logic       reset = 1;
    logic       rx = 1;
    logic       s_tick = 0;
    logic [3:0] data_bits = 4'd8;
    logic [5:0] stop_bits = 6'd16;
    logic [1:0] parity_bits = 2'd0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int n0;
    logic [9:0] cap_q[$];
    logic [9:0] c;
    logic [1:0] tcnt = 0;

    uart_rx #(.SYNC_STAGES(2), .SB_TICK(16)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .s_tick(s_tick),
        .data_bits(data_bits),
        .stop_bits(stop_bits),
        .parity_bits(parity_bits),
        .dout(dout),
        .rx_done_tick(rx_done_tick),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // s_tick changes on the falling edge so it is stable at posedge
    always @(negedge clk) begin
        tcnt   <= tcnt + 2'd1;
        s_tick <= (tcnt == 2'd3);
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt++;
            cap_q.push_back({parity_err, frame_err, dout});
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!s_tick);
        end
    endtask

    task automatic drive(input logic v, input int n);
        #1 rx = v;
        wait_ticks(n);
    endtask

    task automatic get_cap(output logic [9:0] r);
        if (cap_q.size() > 0) r = cap_q.pop_front();
        else r = '1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb,
                              input int par, input int stp,
                              input logic bad_par,
                              input logic bad_stop);
        logic [7:0] dm;
        logic p;
        dm = d & 8'((9'd1 << nb) - 9'd1);
        drive(1'b0, 16);
        for (int i = 0; i < nb; i++) drive(dm[i], 16);
        if (par != 0) begin
            p = (par == 1) ? ~^dm : ^dm;
            if (bad_par) p = ~p;
            drive(p, 16);
        end
        drive(~bad_stop, stp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_done", rx_done_tick, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", rx_busy, 0);
        #1 reset = 0;
        wait_ticks(4);

        // 8N1 0xA5
        n0 = done_cnt;
        send_frame(8'hA5, 8, 0, 16, 0, 0);
        #1 rx = 1;
        wait_ticks(4);
        check("a5_cnt", done_cnt - n0, 1);
        get_cap(c);
        check("a5_cap", c, {2'b00, 8'hA5});

        // 7O2 0x53, then corrupted parity
        data_bits = 4'd7; parity_bits = 2'd1; stop_bits = 6'd32;
        wait_ticks(2);
        send_frame(8'h53, 7, 1, 32, 0, 0);
        send_frame(8'h53, 7, 1, 32, 1, 0);
        #1 rx = 1;
        wait_ticks(4);
        get_cap(c);
        check("7o_good", c, {2'b00, 8'h53});
        get_cap(c);
        check("7o_bad", c, {2'b10, 8'h53});

        // 8E1 back-to-back
        data_bits = 4'd8; parity_bits = 2'd2; stop_bits = 6'd16;
        wait_ticks(2);
        n0 = done_cnt;
        send_frame(8'hFF, 8, 2, 16, 0, 0);
        send_frame(8'h00, 8, 2, 16, 0, 0);
        #1 rx = 1;
        wait_ticks(4);
        check("8e_cnt", done_cnt - n0, 2);
        get_cap(c);
        check("8e_ff", c, {2'b00, 8'hFF});
        get_cap(c);
        check("8e_00", c, {2'b00, 8'h00});

        // start glitch
        parity_bits = 2'd0;
        n0 = done_cnt;
        wait_ticks(1);
        drive(1'b0, 5);
        drive(1'b1, 3);
        @(negedge clk);
        check("gl_busy", rx_busy, 0);
        wait_ticks(20);
        check("gl_cnt", done_cnt - n0, 0);

        // framing error then break
        send_frame(8'h3C, 8, 0, 16, 0, 1);
        drive(1'b1, 20);
        get_cap(c);
        check("fe_3c", c, {2'b01, 8'h3C});
        n0 = done_cnt;
        drive(1'b0, 200);
        drive(1'b1, 20);
        check("brk_cnt", done_cnt - n0, 1);
        get_cap(c);
        check("brk_cap", c, {2'b01, 8'h00});
        check("brk_busy", rx_busy, 0);

        // reset during data bit 4
        n0 = done_cnt;
        wait_ticks(1);
        drive(1'b1, 0);
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b1, 8);
        check("pre_busy", rx_busy, 1);
        #1 reset = 1;
        #1;
        check("mid_dout", dout, 0);
        check("mid_ferr", frame_err, 0);
        check("mid_busy", rx_busy, 0);
        check("mid_done", rx_done_tick, 0);
        rx = 1;
        wait_ticks(2);
        #1 reset = 0;
        wait_ticks(4);
        check("mid_cnt", done_cnt - n0, 0);
        n0 = done_cnt;
        send_frame(8'h81, 8, 0, 16, 0, 0);
        #1 rx = 1;
        wait_ticks(4);
        check("r81_cnt", done_cnt - n0, 1);
        get_cap(c);
        check("r81_cap", c, {2'b00, 8'h81});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
